ajuste_reloj_ctrl: RTL and testbench
====================================

// Module: ajuste_reloj_ctrl
// PURPOSE
//  Set-mode controller for the calendar clock counter chain (centesimas..decenasMes).
//  In RUN it gates the 100 Hz tick onto `stay` so the chain counts.
//  In a SET state it freezes the chain and steers debounced user presses (with
//  hold auto-repeat) as one-hot add pulses to the field being edited.
//  It also drives a blink flag for the display and returns to RUN on inactivity.
// PARAMETERS
//  HOLD_TICKS     50    tick_cent periods btn_mas must be held before auto-repeat (0.5 s)
//  REPEAT_TICKS   10    tick_cent periods between auto-repeat add pulses (0.1 s)
//  BLINK_TICKS    25    tick_cent periods per parpadeo half-period
//  TIMEOUT_TICKS  3000  tick_cent periods with no button activity before forced RUN (30 s)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  tick_cent  in   1  one-cycle 100 Hz strobe, synchronous to clk
//  btn_modo   in   1  debounced mode button, asynchronous level
//  btn_mas    in   1  debounced increment button, asynchronous level
//  stay       out  1  count-enable pulse to the counter chain
//  add_hora   out  1  one-cycle increment pulse, hours field
//  add_min    out  1  one-cycle increment pulse, minutes field
//  add_dia    out  1  one-cycle increment pulse, day field
//  add_mes    out  1  one-cycle increment pulse, month field
//  campo      out  3  current state code: 0 RUN, 1 HORA, 2 MIN, 3 DIA, 4 MES
//  parpadeo   out  1  1 = edited field visible; toggles in SET states; 0 in RUN
// BEHAVIOUR
//  - Reset (rst=0, async): state RUN; all outputs 0; sync flops, repeat/blink/timeout counters cleared.
//  - btn_modo and btn_mas each pass through a 2-FF synchronizer.
//    A rising edge of the synchronized level is an "edge".
//    Button high at clk edge N -> edge acted on at edge N+2.
//  - State sequence on each btn_modo edge: RUN->HORA->MIN->DIA->MES->RUN.
//  - All outputs are registered.
//  - stay: in RUN, high exactly one cycle, the cycle after each tick_cent. Always 0 in SET states.
//  - add_*: only the add_* of the current field can pulse; never in RUN; at most one high per cycle.
//    btn_mas edge in a SET state -> that add_* high exactly one cycle.
//  - Auto-repeat:
//    While synced btn_mas stays high, the hold counter counts tick_cent.
//    At HOLD_TICKS -> one add pulse; thereafter one add pulse every REPEAT_TICKS ticks.
//    Release clears the counter.
//  - Simultaneous btn_modo and btn_mas edges: mode wins; state advances; no add pulse.
//  - On any state change: repeat counter cleared, parpadeo=1, blink counter cleared.
//    A btn_mas held across a mode change does not auto-repeat until released and re-pressed.
//  - parpadeo inverts after every BLINK_TICKS tick_cent strobes while in a SET state.
//  - Timeout counter:
//    Cleared on any edge and while synced btn_mas is high.
//    Counts tick_cent in SET states.
//    At TIMEOUT_TICKS -> state RUN (same effect as leaving MES).
//    In RUN the counter is held at 0.
//  - tick_cent arriving in a SET state is not stored.
//    After return to RUN, stay resumes with the next tick_cent.
//  - Counter widths: $clog2(param+1) bits; counters saturate, never wrap.
// TESTING
//  1. Release rst, 5 tick_cent strobes, no buttons -> 5 stay pulses, each 1 cycle after its tick; campo=0, add_*=0.
//  2. btn_modo edge x2 -> campo=2, stay stuck 0; one btn_mas press -> exactly one add_min pulse, 2 cycles after press.
//  3. In campo=1, hold btn_mas 100 ticks -> add_hora at ticks 0(edge), 50, 60, 70, 80, 90, 100 (7 pulses); release -> none.
//  4. btn_modo and btn_mas rise same cycle in campo=3 -> campo=4, no add_dia/add_mes pulse.
//  5. Enter campo=1, no input for 3000 ticks -> campo=0 at tick 3000, stay resumes on next tick; parpadeo=0.
//  6. rst low mid auto-repeat in campo=4 -> immediately campo=0, all outputs 0; after release, btn_mas gives no add.

Source files
------------

// File: rtl/ajuste_reloj_ctrl.sv
// Set-mode controller for the calendar counter chain: gates the 100 Hz tick in RUN,
// steers debounced increment presses (with hold auto-repeat) to the field being edited.
module ajuste_reloj_ctrl #(
   parameter int HOLD_TICKS    = 50,
   parameter int REPEAT_TICKS  = 10,
   parameter int BLINK_TICKS   = 25,
   parameter int TIMEOUT_TICKS = 3000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_cent,
   input  logic       btn_modo,
   input  logic       btn_mas,
   output logic       stay,
   output logic       add_hora,
   output logic       add_min,
   output logic       add_dia,
   output logic       add_mes,
   output logic [2:0] campo,
   output logic       parpadeo
);

   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_TICKS);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      RUN  = 3'd0,
      HORA = 3'd1,
      MIN  = 3'd2,
      DIA  = 3'd3,
      MES  = 3'd4
   } state_t;

   state_t          state_reg, state_next;
   logic            modo_s1, modo_s2, modo_d;
   logic            mas_s1, mas_s2, mas_d;
   logic [HW-1:0]   hold_cnt;
   logic [RW-1:0]   rep_cnt;
   logic [BW-1:0]   blink_cnt;
   logic [TW-1:0]   to_cnt;
   logic            rep_block;
   logic            stay_reg, parpadeo_reg;
   logic [3:0]      add_reg;

   logic modo_edge, mas_edge, in_set, hold_active;
   logic hold_fire, rep_fire, add_fire, timeout_fire, change;

   assign modo_edge   = modo_s2 & ~modo_d;
   assign mas_edge    = mas_s2 & ~mas_d;
   assign in_set      = (state_reg != RUN);
   assign hold_active = in_set && mas_s2 && !rep_block;
   assign hold_fire   = hold_active && tick_cent && (hold_cnt == HOLD_LAST);
   assign rep_fire    = hold_active && tick_cent && (hold_cnt == HOLD_MAX) && (rep_cnt == REP_LAST);
   // Mode edge wins over any simultaneous increment source.
   assign add_fire    = in_set && !modo_edge && (mas_edge || hold_fire || rep_fire);
   assign timeout_fire = in_set && tick_cent && !mas_s2 && !mas_edge && !modo_edge && (to_cnt == TO_LAST);

   always_comb begin
      state_next = state_reg;
      if (modo_edge) begin
         case (state_reg)
            RUN:     state_next = HORA;
            HORA:    state_next = MIN;
            MIN:     state_next = DIA;
            DIA:     state_next = MES;
            default: state_next = RUN;
         endcase
      end else if (timeout_fire) begin
         state_next = RUN;
      end
   end

   assign change = (state_next != state_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= RUN;
         modo_s1      <= 1'b0;
         modo_s2      <= 1'b0;
         modo_d       <= 1'b0;
         mas_s1       <= 1'b0;
         mas_s2       <= 1'b0;
         mas_d        <= 1'b0;
         hold_cnt     <= '0;
         rep_cnt      <= '0;
         blink_cnt    <= '0;
         to_cnt       <= '0;
         rep_block    <= 1'b0;
         stay_reg     <= 1'b0;
         parpadeo_reg <= 1'b0;
         add_reg      <= '0;
      end else begin
         modo_s1   <= btn_modo;
         modo_s2   <= modo_s1;
         modo_d    <= modo_s2;
         mas_s1    <= btn_mas;
         mas_s2    <= mas_s1;
         mas_d     <= mas_s2;
         state_reg <= state_next;
         stay_reg  <= !in_set && tick_cent;

         add_reg <= '0;
         if (add_fire) begin
            case (state_reg)
               HORA:    add_reg <= 4'b0001;
               MIN:     add_reg <= 4'b0010;
               DIA:     add_reg <= 4'b0100;
               MES:     add_reg <= 4'b1000;
               default: add_reg <= 4'b0000;
            endcase
         end

         if (change) begin
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            blink_cnt    <= '0;
            // A press still held across the change must be released before repeating.
            rep_block    <= mas_s2;
            parpadeo_reg <= (state_next != RUN);
         end else begin
            if (!mas_s2)
               rep_block <= 1'b0;
            if (!hold_active) begin
               hold_cnt <= '0;
               rep_cnt  <= '0;
            end else if (tick_cent) begin
               if (hold_cnt != HOLD_MAX)
                  hold_cnt <= hold_cnt + HW'(1);
               else if (rep_cnt == REP_LAST)
                  rep_cnt <= '0;
               else
                  rep_cnt <= rep_cnt + RW'(1);
            end
            if (in_set && tick_cent) begin
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt    <= '0;
                  parpadeo_reg <= ~parpadeo_reg;
               end else begin
                  blink_cnt <= blink_cnt + BW'(1);
               end
            end
         end

         if (!in_set || change || modo_edge || mas_edge || mas_s2)
            to_cnt <= '0;
         else if (tick_cent && to_cnt != TO_MAX)
            to_cnt <= to_cnt + TW'(1);
      end
   end

   assign stay     = stay_reg;
   assign add_hora = add_reg[0];
   assign add_min  = add_reg[1];
   assign add_dia  = add_reg[2];
   assign add_mes  = add_reg[3];
   assign campo    = state_reg;
   assign parpadeo = parpadeo_reg;

endmodule

// File: tb/tb_ajuste_reloj_ctrl.sv
// Scoreboard bench: expected stay/add pulses are queued with their cycle when stimulus
// is driven, and a negedge monitor pops and compares every pulse the controller emits.
module tb_ajuste_reloj_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_cent = 1'b0;
   logic       btn_modo = 1'b0;
   logic       btn_mas = 1'b0;
   logic       stay, add_hora, add_min, add_dia, add_mes;
   logic [2:0] campo;
   logic       parpadeo;

   localparam logic [4:0] K_STAY = 5'b10000;
   localparam logic [4:0] K_HORA = 5'b01000;
   localparam logic [4:0] K_MIN  = 5'b00100;
   localparam logic [4:0] K_DIA  = 5'b00010;
   localparam logic [4:0] K_MES  = 5'b00001;

   typedef struct {
      int         cyc;
      logic [4:0] kind;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   ajuste_reloj_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .tick_cent (tick_cent),
      .btn_modo  (btn_modo),
      .btn_mas   (btn_mas),
      .stay      (stay),
      .add_hora  (add_hora),
      .add_min   (add_min),
      .add_dia   (add_dia),
      .add_mes   (add_mes),
      .campo     (campo),
      .parpadeo  (parpadeo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      logic [4:0] k;
      exp_t e;
      k = {stay, add_hora, add_min, add_dia, add_mes};
      if (rst && k != 5'b0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got kind=%b at cycle %0d, required none", k, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.cyc != cyc) begin
               bad++;
               $display("FAIL pulse: got kind=%b cycle=%0d, required kind=%b cycle=%0d", k, cyc, e.kind, e.cyc);
            end else begin
               $display("pulse ok: kind=%b cycle=%0d", k, cyc);
            end
         end
      end
   end

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) clk1();
   endtask

   task automatic press_modo();
      btn_modo = 1'b1;
      idle(3);
      btn_modo = 1'b0;
      idle(3);
   endtask

   task automatic tick_once(input bit expect_stay);
      tick_cent = 1'b1;
      if (expect_stay) exp_q.push_back('{cyc + 1, K_STAY});
      clk1();
      tick_cent = 1'b0;
      clk1();
   endtask

   task automatic test_reset();
      idle(3);
      total++;
      if ({campo, parpadeo, stay, add_hora, add_min, add_dia, add_mes} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outputs: got campo=%0d parpadeo=%b stay=%b adds=%b%b%b%b, required all 0",
                  campo, parpadeo, stay, add_hora, add_min, add_dia, add_mes);
      end
      $display("test_reset: campo=%0d parpadeo=%b", campo, parpadeo);
      rst = 1'b1;
      idle(3);
   endtask

   task automatic test_run();
      for (int i = 0; i < 5; i++) begin
         tick_once(1'b1);
         idle(2);
      end
      idle(3);
      total++;
      if (campo !== 3'd0) begin
         bad++;
         $display("FAIL run_campo: got %0d, required 0", campo);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL run_missing: got %0d pulses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_set_edit();
      press_modo();
      press_modo();
      total++;
      if (campo !== 3'd2) begin
         bad++;
         $display("FAIL edit_campo: got %0d, required 2", campo);
      end
      tick_once(1'b0);
      tick_once(1'b0);
      btn_mas = 1'b1;
      exp_q.push_back('{cyc + 3, K_MIN});
      idle(4);
      btn_mas = 1'b0;
      idle(6);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL edit_missing: got %0d pulses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_mode_wins();
      press_modo();
      total++;
      if (campo !== 3'd3) begin
         bad++;
         $display("FAIL wins_pre_campo: got %0d, required 3", campo);
      end
      btn_modo = 1'b1;
      btn_mas  = 1'b1;
      idle(4);
      btn_modo = 1'b0;
      btn_mas  = 1'b0;
      idle(6);
      total++;
      if (campo !== 3'd4 || parpadeo !== 1'b1) begin
         bad++;
         $display("FAIL wins_campo: got campo=%0d parpadeo=%b, required campo=4 parpadeo=1", campo, parpadeo);
      end
      $display("test_mode_wins: campo=%0d", campo);
   endtask

   task automatic test_autorepeat();
      press_modo();
      press_modo();
      total++;
      if (campo !== 3'd1) begin
         bad++;
         $display("FAIL rep_campo: got %0d, required 1", campo);
      end
      btn_mas = 1'b1;
      exp_q.push_back('{cyc + 3, K_HORA});
      idle(4);
      for (int i = 1; i <= 100; i++) begin
         if (i >= 50 && (i - 50) % 10 == 0) exp_q.push_back('{cyc + 1, K_HORA});
         tick_cent = 1'b1;
         clk1();
         tick_cent = 1'b0;
         if (i == 25 || i == 50) begin
            total++;
            if (parpadeo !== (i == 50)) begin
               bad++;
               $display("FAIL blink_tick%0d: got %b, required %b", i, parpadeo, (i == 50));
            end
         end
         clk1();
      end
      btn_mas = 1'b0;
      idle(4);
      for (int i = 0; i < 15; i++) tick_once(1'b0);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rep_missing: got %0d pulses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 5; i++) press_modo();
      total++;
      if (campo !== 3'd1) begin
         bad++;
         $display("FAIL to_enter: got %0d, required 1", campo);
      end
      for (int i = 1; i <= 3000; i++) begin
         tick_cent = 1'b1;
         clk1();
         tick_cent = 1'b0;
         if (i == 2999) begin
            total++;
            if (campo !== 3'd1) begin
               bad++;
               $display("FAIL to_early: got campo=%0d at tick 2999, required 1", campo);
            end
         end
         if (i == 3000) begin
            total++;
            if (campo !== 3'd0 || parpadeo !== 1'b0) begin
               bad++;
               $display("FAIL to_expire: got campo=%0d parpadeo=%b, required campo=0 parpadeo=0", campo, parpadeo);
            end
         end
         clk1();
      end
      tick_once(1'b1);
      idle(3);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL to_missing: got %0d pulses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) press_modo();
      total++;
      if (campo !== 3'd4) begin
         bad++;
         $display("FAIL rm_campo: got %0d, required 4", campo);
      end
      btn_mas = 1'b1;
      exp_q.push_back('{cyc + 3, K_MES});
      idle(4);
      for (int i = 1; i <= 55; i++) begin
         if (i == 50) exp_q.push_back('{cyc + 1, K_MES});
         tick_once(1'b0);
      end
      rst = 1'b0;
      #2;
      total++;
      if ({campo, parpadeo, stay, add_hora, add_min, add_dia, add_mes} !== 9'b0) begin
         bad++;
         $display("FAIL rm_async: got campo=%0d parpadeo=%b stay=%b adds=%b%b%b%b, required all 0",
                  campo, parpadeo, stay, add_hora, add_min, add_dia, add_mes);
      end
      idle(2);
      rst = 1'b1;
      idle(6);
      btn_mas = 1'b0;
      idle(3);
      btn_mas = 1'b1;
      idle(6);
      btn_mas = 1'b0;
      idle(4);
      total++;
      if (campo !== 3'd0) begin
         bad++;
         $display("FAIL rm_after: got campo=%0d, required 0", campo);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rm_missing: got %0d pulses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_set_edit();
      test_mode_wins();
      test_autorepeat();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
